// File: rtl/motor_speed_ramp.sv
// Slew-limited speed/direction front end for the pwm block.
// Converts speed/direction commands into a pulse_width that moves at most one
// level every RAMP_TICKS clocks, with a zero-speed dead interval before reversal.
//
// state  | meaning
// -------+--------------------------------------------------------------
// STEADY | output matches target (or is parked at 0), counter idle at 0
// RAMP   | stepping pulse_width one level per RAMP_TICKS toward target
// DEAD   | pulse_width held at 0 for DEAD_TICKS, then dir takes target
module motor_speed_ramp #(
    parameter int WIDTH      = 3,
    parameter int MAX_LEVEL  = 5,
    parameter int RAMP_TICKS = 1000,
    parameter int DEAD_TICKS = 500
) (
    input  logic             clk,
    input  logic             sys_rst_n,
    input  logic             cmd_valid,
    input  logic [WIDTH-1:0] cmd_speed,
    input  logic             cmd_dir,
    input  logic             estop,
    output logic [WIDTH-1:0] pulse_width,
    output logic             dir,
    output logic             busy
);

    localparam int MAX_T = (RAMP_TICKS > DEAD_TICKS) ? RAMP_TICKS : DEAD_TICKS;
    localparam int CW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    localparam logic [CW-1:0]    RAMP_LAST = CW'(RAMP_TICKS - 1);
    localparam logic [CW-1:0]    DEAD_LAST = CW'(DEAD_TICKS - 1);
    localparam logic [WIDTH-1:0] MAX_L     = WIDTH'(MAX_LEVEL);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    typedef enum logic [1:0] {
        STEADY = 2'd0,
        RAMP   = 2'd1,
        DEAD   = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic [WIDTH-1:0] target_speed, target_speed_next;
    logic             target_dir, target_dir_next;
    logic [WIDTH-1:0] pw_next;
    logic             dir_next;
    logic [WIDTH-1:0] eff_target;
    logic [WIDTH-1:0] pw_step;

    // While a reversal is pending the motor must first come down to zero.
    assign eff_target = (target_dir != dir) ? '0 : target_speed;
    assign pw_step    = (pulse_width < eff_target) ? (pulse_width + ONE)
                                                   : (pulse_width - ONE);

    // State, counter and output register bank.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= STEADY;
            cnt          <= '0;
            target_speed <= '0;
            target_dir   <= 1'b0;
            pulse_width  <= '0;
            dir          <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            target_speed <= target_speed_next;
            target_dir   <= target_dir_next;
            pulse_width  <= pw_next;
            dir          <= dir_next;
            busy         <= (state_next != STEADY);
        end
    end

    // Next-state logic; all decisions use the already-registered target.
    always_comb begin
        state_next        = state;
        cnt_next          = cnt;
        target_speed_next = target_speed;
        target_dir_next   = target_dir;
        pw_next           = pulse_width;
        dir_next          = dir;

        if (estop) begin
            // dir and target_dir hold so no reversal is implied by a stop.
            state_next        = STEADY;
            cnt_next          = '0;
            target_speed_next = '0;
            pw_next           = '0;
        end else begin
            if (cmd_valid) begin
                target_speed_next = (cmd_speed > MAX_L) ? MAX_L : cmd_speed;
                target_dir_next   = cmd_dir;
            end

            case (state)
                STEADY: begin
                    cnt_next = '0;
                    if (pulse_width != eff_target) begin
                        state_next = RAMP;
                    end else if (dir != target_dir) begin
                        // Already at zero: only the dead interval remains.
                        state_next = DEAD;
                    end
                end

                RAMP: begin
                    if (pulse_width == eff_target) begin
                        // A retarget landed exactly on the current level.
                        cnt_next   = '0;
                        state_next = (dir != target_dir) ? DEAD : STEADY;
                    end else if (cnt == RAMP_LAST) begin
                        cnt_next = '0;
                        pw_next  = pw_step;
                        if (pw_step == eff_target) begin
                            state_next = (dir != target_dir) ? DEAD : STEADY;
                        end
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end

                DEAD: begin
                    pw_next = '0;
                    if (cnt == DEAD_LAST) begin
                        cnt_next   = '0;
                        dir_next   = target_dir;
                        state_next = (target_speed != '0) ? RAMP : STEADY;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end

                default: begin
                    state_next = STEADY;
                    cnt_next   = '0;
                    pw_next    = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_motor_speed_ramp.sv
// Scoreboard bench for motor_speed_ramp with RAMP_TICKS=4, DEAD_TICKS=3.
// Each change of {pulse_width, dir, busy} is an output event; stimulus pushes
// the expected events (value plus clock gap) and a monitor pops and compares.
module tb_motor_speed_ramp;

    localparam int W  = 3;
    localparam int RT = 4;
    localparam int DT = 3;

    logic         clk = 1'b0;
    logic         sys_rst_n;
    logic         cmd_valid;
    logic [W-1:0] cmd_speed;
    logic         cmd_dir;
    logic         estop;
    logic [W-1:0] pulse_width;
    logic         dir;
    logic         busy;

    motor_speed_ramp #(
        .WIDTH(W), .MAX_LEVEL(5), .RAMP_TICKS(RT), .DEAD_TICKS(DT)
    ) dut (
        .clk(clk), .sys_rst_n(sys_rst_n), .cmd_valid(cmd_valid),
        .cmd_speed(cmd_speed), .cmd_dir(cmd_dir), .estop(estop),
        .pulse_width(pulse_width), .dir(dir), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pw;
        int dr;
        int bz;
        int gap;      // -1: do not check timing
        bit from_cmd; // gap measured from command capture edge, else from previous event
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   cmd_cyc  = 0;
    int   last_evt_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic push(input int pw, input int dr, input int bz, input int gap, input bit fc);
        exp_t e;
        e.pw = pw; e.dr = dr; e.bz = bz; e.gap = gap; e.from_cmd = fc;
        exp_q.push_back(e);
    endtask

    // Drive a one-cycle command from a negedge; capture happens at the next posedge.
    task automatic send_cmd(input int spd, input bit d);
        cmd_valid = 1'b1;
        cmd_speed = W'(spd);
        cmd_dir   = d;
        cmd_cyc   = cyc + 1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_pw(input int lvl, input int budget);
        int n;
        n = 0;
        while (int'(pulse_width) != lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (int'(pulse_width) != lvl)
            chk("timeout_wait_pw", int'(pulse_width), lvl);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: pop and compare on every output change.
    initial begin : monitor
        logic [W-1:0] p_pw;
        logic         p_dir;
        logic         p_bz;
        exp_t         e;
        int           gap;
        p_pw = '0; p_dir = 1'b0; p_bz = 1'b0;
        forever begin
            @(negedge clk);
            if (pulse_width != p_pw || dir != p_dir || busy != p_bz) begin
                if (dir != p_dir) chk("dir_flip_at_zero", int'(pulse_width), 0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_event: got pw=%0d dir=%0d busy=%0d, expected no change (cycle %0d)",
                             pulse_width, dir, busy, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("evt_pw", int'(pulse_width), e.pw);
                    chk("evt_dir", int'(dir), e.dr);
                    chk("evt_busy", int'(busy), e.bz);
                    if (e.gap >= 0) begin
                        gap = e.from_cmd ? (cyc - cmd_cyc) : (cyc - last_evt_cyc);
                        chk(e.from_cmd ? "gap_from_cmd" : "gap_step", gap, e.gap);
                    end
                end
                last_evt_cyc = cyc;
            end
            p_pw = pulse_width; p_dir = dir; p_bz = busy;
        end
    end

    initial begin : stimulus
        sys_rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_speed = '0;
        cmd_dir   = 1'b0;
        estop     = 1'b0;
        idle(3);
        chk("reset_pw", int'(pulse_width), 0);
        chk("reset_dir", int'(dir), 0);
        chk("reset_busy", int'(busy), 0);
        sys_rst_n = 1'b1;
        idle(3);

        // Ramp up 0 -> 5: busy rises one clock after capture, steps every RT.
        push(0, 0, 1, 1, 1);
        for (int l = 1; l <= 5; l++) push(l, 0, (l == 5) ? 0 : 1, RT, 0);
        send_cmd(5, 0);
        wait_pw(5, 60);
        idle(3);

        // Over-range command clamps to 5: nothing should move.
        send_cmd(7, 0);
        idle(12);
        chk("clamp_pw", int'(pulse_width), 5);
        chk("clamp_busy", int'(busy), 0);

        // Ramp down 5 -> 2.
        push(5, 0, 1, 1, 1);
        push(4, 0, 1, RT, 0);
        push(3, 0, 1, RT, 0);
        push(2, 0, 0, RT, 0);
        send_cmd(2, 0);
        wait_pw(2, 40);
        idle(3);

        // Back up to 3 to set up the reversal.
        push(2, 0, 1, 1, 1);
        push(3, 0, 0, RT, 0);
        send_cmd(3, 0);
        wait_pw(3, 20);
        idle(3);

        // Reversal 3 fwd -> 2 rev: down to 0, dead for DT, flip, up to 2.
        push(3, 0, 1, 1, 1);
        push(2, 0, 1, RT, 0);
        push(1, 0, 1, RT, 0);
        push(0, 0, 1, RT, 0);
        push(0, 1, 1, DT, 0);
        push(1, 1, 1, RT, 0);
        push(2, 1, 0, RT, 0);
        send_cmd(2, 1);
        wait_pw(0, 40);
        wait_pw(2, 40);
        idle(3);
        chk("rev_dir", int'(dir), 1);

        // Estop at level 4 while ramping toward 5; command during estop ignored.
        push(2, 1, 1, 1, 1);
        push(3, 1, 1, RT, 0);
        push(4, 1, 1, RT, 0);
        send_cmd(5, 1);
        wait_pw(4, 40);
        @(negedge clk);
        push(0, 1, 0, 2, 0);
        estop     = 1'b1;
        cmd_valid = 1'b1;
        cmd_speed = 3'd5;
        cmd_dir   = 1'b0;
        @(negedge clk);
        estop     = 1'b0;
        cmd_valid = 1'b0;
        chk("estop_pw", int'(pulse_width), 0);
        chk("estop_busy", int'(busy), 0);
        idle(15);
        chk("post_estop_pw", int'(pulse_width), 0);
        chk("post_estop_dir", int'(dir), 1);

        // Retarget mid-ramp: at level 2 heading for 5, command 1; no counter restart.
        push(0, 1, 1, 1, 1);
        push(1, 1, 1, RT, 0);
        push(2, 1, 1, RT, 0);
        send_cmd(5, 1);
        wait_pw(2, 40);
        push(1, 1, 0, RT, 0);
        send_cmd(1, 1);
        wait_pw(1, 20);
        idle(6);
        chk("retarget_pw", int'(pulse_width), 1);

        // Async reset during DEAD.
        push(1, 1, 1, 1, 1);
        push(0, 1, 1, RT, 0);
        send_cmd(1, 0);
        wait_pw(0, 20);
        push(0, 0, 0, -1, 0);
        #3;
        sys_rst_n = 1'b0;
        #1;
        chk("arst_pw", int'(pulse_width), 0);
        chk("arst_dir", int'(dir), 0);
        chk("arst_busy", int'(busy), 0);
        idle(3);
        sys_rst_n = 1'b1;
        idle(20);
        chk("post_rst_pw", int'(pulse_width), 0);
        chk("post_rst_dir", int'(dir), 0);
        chk("post_rst_busy", int'(busy), 0);

        // Drain and report leftovers.
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            $display("FAIL missing_event: got none, expected pw=%0d dir=%0d busy=%0d", e.pw, e.dr, e.bz);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
